// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-packed-BCD converter with start/busy/done handshake.
// Optional build macro AUTO_CONVERT_EN: start a conversion automatically whenever bin_in changes.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 13,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SCR_W = 4 * (DIGITS + 1);
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [BCD_W-1:0] NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [BIN_W-1:0]   sh, sh_n;
  logic [SCR_W-1:0]   scr, scr_n, adj_c;
  logic               busy_n, done_n, ovf_n;
  logic [BCD_W-1:0]   bcd_n;
  logic               go_c;

`ifdef AUTO_CONVERT_EN
  logic [BIN_W-1:0]   last_val;

  assign go_c = start | (bin_in != last_val);

  // Remembers the value of the most recent accepted conversion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_val <= '0;
    end else if (state == IDLE && go_c) begin
      last_val <= bin_in;
    end
  end
`else
  assign go_c = start;
`endif

  // Per-nibble add-3 correction; nibbles are independent, no carry.
  always_comb begin
    adj_c = scr;
    for (int unsigned i = 0; i <= DIGITS; i++) begin
      if (scr[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = scr[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      scr      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sh       <= sh_n;
      scr      <= scr_n;
      busy     <= busy_n;
      done     <= done_n;
      bcd_out  <= bcd_n;
      overflow <= ovf_n;
    end
  end

  // SHIFT spends one extra cycle after the last iteration so busy spans BIN_W+1 cycles.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    scr_n   = scr;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    bcd_n   = bcd_out;
    ovf_n   = overflow;
    case (state)
      IDLE: begin
        if (go_c) begin
          state_n = SHIFT;
          sh_n    = bin_in;
          scr_n   = '0;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        busy_n = 1'b1;
        if (cnt == CNT_W'(BIN_W)) begin
          state_n = DONE;
        end else begin
          {scr_n, sh_n} = {adj_c[SCR_W-2:0], sh, 1'b0};
          cnt_n         = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        done_n  = 1'b1;
        if (|scr[SCR_W-1 -: 4]) begin
          ovf_n = 1'b1;
          bcd_n = NINES;
        end else begin
          ovf_n = 1'b0;
          bcd_n = scr[BCD_W-1:0];
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
